// File: rtl/reg_alu_pipe_pkg.sv
// Shared opcode, write-back select, flag position and FSM encodings for reg_alu_pipe.
package reg_alu_pipe_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_LSH = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam logic [2:0] WB_PC   = 3'd0;
    localparam logic [2:0] WB_COND = 3'd1;
    localparam logic [2:0] WB_ALU  = 3'd2;
    localparam logic [2:0] WB_MEM  = 3'd3;
    localparam logic [2:0] WB_DROM = 3'd4;

    localparam int unsigned PSR_C = 0;
    localparam int unsigned PSR_L = 1;
    localparam int unsigned PSR_F = 2;
    localparam int unsigned PSR_Z = 3;
    localparam int unsigned PSR_N = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low DATAWIDTH bits kept.
module mul_iter #(
    parameter int unsigned DATAWIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done_c,
    output logic [DATAWIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(DATAWIDTH);

    logic [DATAWIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;

    // High during the cycle whose closing edge performs the final iteration.
    assign done_c  = busy_q && (cnt_q == CW'(DATAWIDTH - 1));
    assign busy    = busy_q;
    assign product = acc_q;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            a_d    = a;
            b_d    = b;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (b_q[0]) begin
                acc_d = acc_q + a_q;
            end
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (done_c) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/reg_alu_pipe.sv
// Two-stage register-file/ALU pipeline (EX then WB) with WB->EX forwarding and an
// iterative multiplier that stalls issue while it runs.
module reg_alu_pipe
    import reg_alu_pipe_pkg::*;
#(
    parameter  int unsigned DATAWIDTH = 16,
    parameter  int unsigned REGCOUNT  = 16,
    parameter  int unsigned IMMWIDTH  = 8,
    localparam int unsigned REGWIDTH  = $clog2(REGCOUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic                 write,
    input  logic                 IMM_MUX,
    input  logic [2:0]           WB_MUX,
    input  logic [REGWIDTH-1:0]  rSrc,
    input  logic [REGWIDTH-1:0]  rDst,
    input  logic [3:0]           aluOp,
    input  logic [IMMWIDTH-1:0]  imm_in,
    input  logic                 COND_RSLT,
    input  logic [DATAWIDTH-1:0] pc_ra,
    input  logic [DATAWIDTH-1:0] mem_data,
    input  logic [DATAWIDTH-1:0] drom,
    output logic [DATAWIDTH-1:0] dSrc,
    output logic [DATAWIDTH-1:0] dDst,
    output logic [DATAWIDTH-1:0] alu_Result,
    output logic [4:0]           psrOut,
    output logic                 wb_valid,
    output logic [REGWIDTH-1:0]  wb_reg
);

    localparam int unsigned MSB = DATAWIDTH - 1;

    logic [DATAWIDTH-1:0] regs_q [REGCOUNT];

    state_e               state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [REGWIDTH-1:0]  wb_reg_q, wb_reg_d;
    logic [DATAWIDTH-1:0] wb_data_q, wb_data_d;
    logic [DATAWIDTH-1:0] alu_q, alu_d;
    logic [4:0]           psr_q, psr_d;
    logic                 mul_wr_q, mul_wr_d;
    logic [REGWIDTH-1:0]  mul_dst_q, mul_dst_d;

    logic [DATAWIDTH-1:0] imm_ex_c, src_c, alu_res_c, wb_mux_c, mul_product;
    logic [DATAWIDTH:0]   sum_c, diff_c;
    logic [3:0]           shamt_c;
    logic [4:0]           psr_new_c;
    logic                 accept_c, mul_start_c, mul_busy, mul_done_c;

    // Reads see the value WB is about to write, so dependent ops issue back to back.
    assign dSrc = (wb_valid_q && (wb_reg_q == rSrc)) ? wb_data_q : regs_q[rSrc];
    assign dDst = (wb_valid_q && (wb_reg_q == rDst)) ? wb_data_q : regs_q[rDst];

    assign imm_ex_c    = DATAWIDTH'($signed(imm_in));
    assign src_c       = IMM_MUX ? imm_ex_c : dSrc;
    assign accept_c    = valid_in && ready_q;
    assign mul_start_c = accept_c && (state_q == IDLE) && (aluOp == OP_MUL);

    assign ready_out  = ready_q;
    assign wb_valid   = wb_valid_q;
    assign wb_reg     = wb_reg_q;
    assign alu_Result = alu_q;
    assign psrOut     = psr_q;

    always_comb begin
        sum_c     = {1'b0, dDst} + {1'b0, src_c};
        diff_c    = {1'b0, dDst} - {1'b0, src_c};
        shamt_c   = src_c[MSB] ? 4'(-src_c) : src_c[3:0];
        alu_res_c = src_c;
        psr_new_c = psr_q;
        case (aluOp)
            OP_ADD: begin
                alu_res_c        = sum_c[MSB:0];
                psr_new_c[PSR_C] = sum_c[DATAWIDTH];
                psr_new_c[PSR_F] = (dDst[MSB] == src_c[MSB]) && (sum_c[MSB] != dDst[MSB]);
            end
            OP_SUB: begin
                alu_res_c        = diff_c[MSB:0];
                psr_new_c[PSR_C] = diff_c[DATAWIDTH];
                psr_new_c[PSR_F] = (dDst[MSB] != src_c[MSB]) && (diff_c[MSB] != dDst[MSB]);
            end
            OP_AND: alu_res_c = dDst & src_c;
            OP_OR:  alu_res_c = dDst | src_c;
            OP_XOR: alu_res_c = dDst ^ src_c;
            OP_MOV: alu_res_c = src_c;
            OP_LSH: alu_res_c = src_c[MSB] ? (dDst >> shamt_c) : (dDst << shamt_c);
            OP_CMP: begin
                // CMP passes dDst through so a write-back leaves the register unchanged.
                alu_res_c        = dDst;
                psr_new_c[PSR_L] = src_c > dDst;
                psr_new_c[PSR_N] = $signed(src_c) > $signed(dDst);
                psr_new_c[PSR_Z] = src_c == dDst;
            end
            default: alu_res_c = src_c;
        endcase
    end

    always_comb begin
        case (WB_MUX)
            WB_PC:   wb_mux_c = pc_ra;
            WB_COND: wb_mux_c = DATAWIDTH'(COND_RSLT);
            WB_ALU:  wb_mux_c = alu_res_c;
            WB_MEM:  wb_mux_c = mem_data;
            WB_DROM: wb_mux_c = drom;
            default: wb_mux_c = '0;
        endcase
    end

    // Issue control; a multiply always writes its product, whatever WB_MUX was.
    always_comb begin
        state_d    = state_q;
        wb_valid_d = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;
        alu_d      = alu_q;
        psr_d      = psr_q;
        mul_wr_d   = mul_wr_q;
        mul_dst_d  = mul_dst_q;
        case (state_q)
            IDLE: begin
                if (mul_start_c) begin
                    state_d   = MUL_BUSY;
                    mul_wr_d  = write;
                    mul_dst_d = rDst;
                end else if (accept_c) begin
                    wb_valid_d = write;
                    wb_reg_d   = rDst;
                    wb_data_d  = wb_mux_c;
                    alu_d      = alu_res_c;
                    psr_d      = psr_new_c;
                end
            end
            MUL_BUSY: begin
                if (mul_busy && mul_done_c) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                state_d    = IDLE;
                wb_valid_d = mul_wr_q;
                wb_reg_d   = mul_dst_q;
                wb_data_d  = mul_product;
                alu_d      = mul_product;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            wb_valid_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
            alu_q      <= '0;
            psr_q      <= '0;
            mul_wr_q   <= 1'b0;
            mul_dst_q  <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            wb_valid_q <= wb_valid_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
            alu_q      <= alu_d;
            psr_q      <= psr_d;
            mul_wr_q   <= mul_wr_d;
            mul_dst_q  <= mul_dst_d;
        end
    end

    // Register array is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (wb_valid_q) begin
            regs_q[wb_reg_q] <= wb_data_q;
        end
    end

    mul_iter #(
        .DATAWIDTH(DATAWIDTH)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start_c),
        .a      (dDst),
        .b      (src_c),
        .busy   (mul_busy),
        .done_c (mul_done_c),
        .product(mul_product)
    );

endmodule

// File: doc/reg_alu_pipe.md
REG_ALU_PIPE -- requirements
Module: reg_alu_pipe

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 16, the datapath and register width.
REQ-002 SHALL have parameter REGCOUNT, default 16, the number of registers; REGWIDTH = clog2(REGCOUNT).
REQ-003 SHALL have parameter IMMWIDTH, default 8, the immediate width before sign extension.
REQ-004 SHALL have the following ports, one per line (name, direction, width, meaning):
  clk  in  1  the single clock, rising edge.
  rst_n  in  1  reset; asynchronous assert, active-low.
  valid_in  in  1  instruction present this cycle.
  ready_out  out  1  the block accepts valid_in this cycle.
  write  in  1  the instruction writes back to rDst.
  IMM_MUX  in  1  selects ALU source: 1 = imm_ex, 0 = dSrc.
  WB_MUX  in  3  write-back source: 0 = pc_ra, 1 = {0, COND_RSLT}, 2 = ALU result, 3 = mem_data, 4 = drom; 5-7 are reserved and write 0.
  rSrc, rDst  in  REGWIDTH  source and destination register indices.
  aluOp  in  4  ALU opcode.
  imm_in  in  IMMWIDTH  immediate value.
  COND_RSLT  in  1  Scond result.
  pc_ra, mem_data, drom  in  DATAWIDTH  write-back data sources.
  dSrc, dDst  out  DATAWIDTH  forwarded read data.
  alu_Result  out  DATAWIDTH  registered ALU result.
  psrOut  out  5  registered flags {N,Z,F,L,C}.
  wb_valid  out  1  a write-back occurs this cycle.
  wb_reg  out  REGWIDTH  the index being written back.

Function
REQ-005 SHALL form a two-stage pipeline: EX (read, ALU, mux) then WB (register-file write); an instruction accepted at edge k writes the register file at edge k+1.
REQ-006 SHALL forward data: if WB holds a valid write to index r, reads of r in EX return the WB data rather than the array value; dSrc and dDst SHALL show the forwarded values.
REQ-007 SHALL sign-extend imm_in to DATAWIDTH.
REQ-008 SHALL implement single-cycle opcodes: 0 ADD, 1 SUB (dDst-src), 2 AND, 3 OR, 4 XOR, 5 MOV (src), 6 LSH (left shift by src[3:0] when src is non-negative, logical right shift by -src when src is negative), 7 CMP (no result, flags only), 8 MUL.
REQ-009 SHALL treat opcodes 9-15 as MOV with no flag update.
REQ-010 SHALL update C and F on ADD and SUB only: C is the carry/borrow out; F is the signed overflow.
REQ-011 SHALL update L, Z and N on CMP only: L = src > dDst unsigned; N = src > dDst signed; Z = equality.
REQ-012 SHALL hold all flags not named for the current opcode.
REQ-013 SHALL register alu_Result and psrOut at the EX-to-WB edge; both hold while no instruction completes.
REQ-014 SHALL implement MUL as an iterative shift-add of the low DATAWIDTH bits, taking DATAWIDTH cycles in a MUL_BUSY state.
REQ-015 SHALL use the FSM states IDLE, MUL_BUSY and MUL_DONE:
  IDLE -> MUL_BUSY when a MUL is accepted;
  MUL_BUSY -> MUL_DONE after DATAWIDTH iterations;
  MUL_DONE -> IDLE in one cycle, passing the product to WB.
REQ-016 SHALL hold ready_out low in MUL_BUSY and MUL_DONE.
REQ-017 SHALL ignore valid_in while ready_out is low.
REQ-018 SHALL set wb_valid=1 for exactly one cycle per accepted instruction with write=1, including MUL; CMP with write=1 writes the unchanged dDst.
REQ-019 SHALL treat valid_in=0 as a bubble: no write-back and no flag change.
REQ-020 SHALL, when rSrc==rDst==r and WB is writing r, forward to both operands.
REQ-021 SHALL forward to a MUL's operands only at acceptance; the operands are latched for the rest of the operation.

Reset
REQ-022 SHALL, while rst_n is low, asynchronously clear: the FSM to IDLE, alu_Result=0, psrOut=0, wb_valid=0, wb_reg=0, the pipeline register and multiplier state.
REQ-023 SHALL hold ready_out=1 during and after reset.
REQ-024 SHALL not reset the register-file array; its contents are undefined until written.
REQ-025 SHALL, on reset during MUL_BUSY, abandon the multiply with no write-back.

Structure
REQ-026 SHALL place opcode constants, the WB_MUX encodings, the PSR bit positions and the FSM state encoding in the shared defines package.
REQ-027 SHALL implement the iterative multiplier as one sub-module, mul_iter (start, operands, busy, done, product).
REQ-028 SHALL keep the register array, forwarding, ALU and WB mux in reg_alu_pipe.

Verification
REQ-029 SHALL cover back-to-back dependency: MOV r1<-imm 5, then ADD r1+=r1 next cycle -> alu_Result=10, r1=10, no stall.
REQ-030 SHALL cover add overflow: ADD 0x7FFF+0x0001 -> result 0x8000, F=1, C=0; then ADD 0xFFFF+0x0001 -> 0x0000, C=1, F=0.
REQ-031 SHALL cover CMP: r2=3, r3=0xFFFE, CMP src=r3 dst=r2 -> L=1, N=0, Z=0, C and F unchanged.
REQ-032 SHALL cover MUL: 7*9 -> ready_out low 17 cycles (DATAWIDTH + done cycle), valid_in ignored meanwhile, rDst=63, one wb_valid pulse.
REQ-033 SHALL cover reset mid-MUL: rst_n low at cycle 5 of MUL -> ready_out=1 immediately, no write, psrOut=0.
REQ-034 SHALL cover write-back sources: WB_MUX=4 with drom=0xBEEF -> rDst=0xBEEF; WB_MUX=1 with COND_RSLT=1 -> rDst=0x0001.
